// File: rtl/fifo_param.sv
// fifo_param: parametrised show-ahead FIFO that uses all DEPTH entries; occupancy count,
// almost flags, flush, sticky errors. Define FIFO_HWM_EN to build the high-water-mark register.
module fifo_param #(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = DEPTH-2,
  parameter int  AE_LEVEL = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             we,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] out,
  input  logic             re,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
  output logic [AW:0]      hwm
);

  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok, rd_ok;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (identical).
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = 32'(count) >= 32'(AF_LEVEL);
  assign almost_empty = 32'(count) <= 32'(AE_LEVEL);
  assign out          = mem[rd_ptr[AW-1:0]];

  // A pop frees a slot in the same edge, so a full FIFO still takes we&re.
  assign wr_ok = we & (~full | re) & ~flush;
  assign rd_ok = re & ~empty & ~flush;

  always_comb begin
    wr_nxt = wr_ptr + {{AW{1'b0}}, wr_ok};
    rd_nxt = rd_ptr + {{AW{1'b0}}, rd_ok};
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= in;
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!flush && we && full && !re) overflow <= 1'b1;
      else if (err_clr)                overflow <= 1'b0;
      if (!flush && re && empty)       underflow <= 1'b1;
      else if (err_clr)                underflow <= 1'b0;
    end
  end

`ifdef FIFO_HWM_EN
  logic [AW:0] cnt_nxt, hwm_q;

  assign cnt_nxt = wr_nxt - rd_nxt;

  // Tracks the next-state count so the mark lands on the same edge as the peak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   hwm_q <= '0;
    else if (flush)             hwm_q <= '0;
    else if (err_clr)           hwm_q <= cnt_nxt;
    else if (cnt_nxt > hwm_q)   hwm_q <= cnt_nxt;
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst, flush, we, re, err_clr;
  logic [7:0] din, dout;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [3:0] count, hwm;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in(din), .we(we), .full(full),
    .almost_full(almost_full), .out(dout), .re(re), .empty(empty),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr), .hwm(hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; re = 0; flush = 0; err_clr = 0;
  endtask

  initial begin
    rst = 0; din = '0;
    idle();
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_hwm", hwm, 0);
    tick(); tick();
    rst = 1;
    tick();

    // 1: fill then drain
    for (int i = 0; i < 8; i++) begin
      we = 1; din = 8'h10 + 8'(i);
      tick();
      chk("t1_count", count, i+1);
      chk("t1_afull", almost_full, (i+1 >= 6));
      chk("t1_full", full, (i+1 == 8));
      chk("t1_aempty", almost_empty, (i+1 <= 2));
      chk("t1_out", dout, 8'h10);
    end
    idle();
`ifdef FIFO_HWM_EN
    chk("t1_hwm", hwm, 8);
`endif
    for (int i = 0; i < 8; i++) begin
      chk("t1_rd", dout, 8'h10 + 8'(i));
      re = 1;
      tick();
    end
    idle();
    chk("t1_empty", empty, 1);
    chk("t1_cnt0", count, 0);

    // 2: overflow on full, then clear
    for (int i = 0; i < 8; i++) begin
      we = 1; din = 8'h20 + 8'(i);
      tick();
    end
    din = 8'hAA;
    tick();
    idle();
    chk("t2_count", count, 8);
    chk("t2_ovf", overflow, 1);
    chk("t2_out", dout, 8'h20);
    err_clr = 1;
    tick();
    idle();
    chk("t2_ovf_clr", overflow, 0);

    // 3: simultaneous read/write on full
    we = 1; re = 1; din = 8'h55;
    tick();
    idle();
    chk("t3_count", count, 8);
    chk("t3_full", full, 1);
    chk("t3_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_rd", dout, (i == 7) ? 8'h55 : 8'h21 + 8'(i));
      re = 1;
      tick();
    end
    idle();
    chk("t3_empty", empty, 1);

    // 4: we&re on empty -> write only, underflow
    we = 1; re = 1; din = 8'h33;
    tick();
    idle();
    chk("t4_unf", underflow, 1);
    chk("t4_count", count, 1);
    chk("t4_out", dout, 8'h33);
    chk("t4_empty", empty, 0);
    err_clr = 1;
    tick();
    idle();
    chk("t4_unf_clr", underflow, 0);
    re = 1;
    tick();
    idle();
    chk("t4_empty2", empty, 1);

    // 5: steady occupancy of 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      we = 1; din = 8'h40 + 8'(i);
      tick();
    end
    idle();
    for (int k = 0; k < 20; k++) begin
      chk("t5_out", dout, 8'h40 + 8'(k));
      we = 1; re = 1; din = 8'h43 + 8'(k);
      tick();
      chk("t5_count", count, 3);
      chk("t5_aempty", almost_empty, 0);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("t5_drain", dout, 8'h54 + 8'(i));
      re = 1;
      tick();
      chk("t5_aempty_lo", almost_empty, 1);
    end
    idle();
    chk("t5_empty", empty, 1);

    // 6: flush priority, hwm, set-wins on err_clr, async reset
    flush = 1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      we = 1; din = 8'h60 + 8'(i);
      tick();
    end
    idle();
    chk("t6_count5", count, 5);
`ifdef FIFO_HWM_EN
    chk("t6_hwm5", hwm, 5);
`endif
    flush = 1; we = 1; din = 8'h77;
    tick();
    idle();
    chk("t6_fl_count", count, 0);
    chk("t6_fl_empty", empty, 1);
    chk("t6_fl_ovf", overflow, 0);
    chk("t6_fl_unf", underflow, 0);
`ifdef FIFO_HWM_EN
    chk("t6_fl_hwm", hwm, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      we = 1; din = 8'h80 + 8'(i);
      tick();
    end
    err_clr = 1;
    tick();
    idle();
    chk("t6_setwins", overflow, 1);
    chk("t6_out", dout, 8'h80);
    err_clr = 1;
    tick();
    idle();
    chk("t6_clr", overflow, 0);
    we = 1; din = 8'h99;
    tick();
    rst = 0;
    #1;
    chk("t6_ar_count", count, 0);
    chk("t6_ar_empty", empty, 1);
    chk("t6_ar_full", full, 0);
    chk("t6_ar_afull", almost_full, 0);
    chk("t6_ar_aempty", almost_empty, 1);
    chk("t6_ar_ovf", overflow, 0);
    chk("t6_ar_hwm", hwm, 0);
    idle();
    tick();
    rst = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
